// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide, one bit per cycle.
// Define ALU_MULDIV_FAST_MUL_EN to resolve multiplies in one cycle with a combinational product.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]         state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic               signed1, signed2, s1, s2, div0, ovf;
  logic [WIDTH-1:0]   mag1, mag2;

  assign signed1 = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
  assign signed2 = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
  assign s1      = signed1 & operand1[WIDTH-1];
  assign s2      = signed2 & operand2[WIDTH-1];
  assign mag1    = s1 ? (-operand1) : operand1;
  assign mag2    = s2 ? (-operand2) : operand2;
  assign div0    = op[2] && (operand2 == '0);
  assign ovf     = op[2] && !op[0] && (operand1 == MIN_NEG) && (operand2 == '1);

`ifdef ALU_MULDIV_FAST_MUL_EN
  // Sign-extending to 2*WIDTH makes a plain modular product correct for every signedness mix.
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{s1}}, operand1} * {{WIDTH{s2}}, operand2};
`endif

  // Multiply: acc = {partial product, remaining multiplier bits}; divide: acc = {remainder, quotient}.
  logic [WIDTH:0]     mul_sum, div_r;
  logic               div_ge;
  logic [2*WIDTH-1:0] mul_next, div_next, prod;
  logic [WIDTH-1:0]   quot, rem, calc_res;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mag_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                             : {1'b0, acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1:1]};
  assign div_r    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge   = div_r >= {1'b0, mag_q};
  assign div_next = {div_ge ? (div_r[WIDTH-1:0] - mag_q) : div_r[WIDTH-1:0],
                     acc_q[WIDTH-2:0], div_ge};
  assign prod     = neg_q ? (-mul_next) : mul_next;
  assign quot     = neg_q ? (-div_next[WIDTH-1:0]) : div_next[WIDTH-1:0];
  assign rem      = rneg_q ? (-div_next[2*WIDTH-1:WIDTH]) : div_next[2*WIDTH-1:WIDTH];
  assign calc_res = op_q[2] ? (op_q[1] ? rem : quot)
                            : ((op_q[1:0] == 2'd0) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH]);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mag_d    = mag_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_CALC: begin
          acc_d = op_q[2] ? div_next : mul_next;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            result_d = calc_res;
            state_d  = S_DONE;
          end
        end
        default: begin
          state_d = S_IDLE;
          if (start) begin
            op_d    = op;
            cnt_d   = '0;
            neg_d   = s1 ^ s2;
            rneg_d  = s1;
            mag_d   = op[2] ? mag2 : mag1;
            acc_d   = {{WIDTH{1'b0}}, op[2] ? mag1 : mag2};
            state_d = S_CALC;
            if (div0) begin
              result_d = op[1] ? operand1 : '1;
              state_d  = S_DONE;
            end else if (ovf) begin
              result_d = op[1] ? '0 : operand1;
              state_d  = S_DONE;
            end
`ifdef ALU_MULDIV_FAST_MUL_EN
            else if (!op[2]) begin
              result_d = (op[1:0] == 2'd0) ? fast_prod[WIDTH-1:0] : fast_prod[2*WIDTH-1:WIDTH];
              state_d  = S_DONE;
            end
`endif
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mag_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mag_q    <= mag_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == S_CALC);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed-vector bench for alu_muldiv (WIDTH=32): results, cycle timing, flush, reset, back-to-back.
module tb_alu_muldiv;

  localparam int W = 32;
`ifdef ALU_MULDIV_FAST_MUL_EN
  localparam int LAT_MUL = 1;
`else
  localparam int LAT_MUL = 33;
`endif
  localparam int LAT_DIV = 33;
  localparam int LAT_SPC = 1;

  logic         clk, rst, start, flush;
  logic [2:0]   op;
  logic [W-1:0] operand1, operand2;
  logic         busy, done;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_errors = 0;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
    .operand1(operand1), .operand2(operand2),
    .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start    = 1'b1;
    op       = o;
    operand1 = a;
    operand2 = b;
  endtask

  // Called in cycle 0 (start already driven); follows the operation until done or 40 cycles.
  task automatic track(input string tag, input logic [W-1:0] exp, input int lat,
                       input int poke_cyc, input int flush_cyc, input bit pulse_chk);
    int busy_cnt = 0;
    int done_cyc = 0;
    bit overlap  = 0;
    bit moved    = 0;
    logic [W-1:0] prev = result;
    for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (busy && done) overlap = 1;
      if (done) done_cyc = c;
      else if (result !== prev) moved = 1;
      flush = (c == flush_cyc);
      if (c == poke_cyc) begin
        issue(3'd0, 32'd3, 32'd5);
      end else begin
        start    = 1'b0;
        op       = 3'($urandom_range(0, 7));
        operand1 = $urandom;
        operand2 = $urandom;
      end
    end
    flush = 1'b0;
    chk({tag, "/done_cycle"}, 64'(done_cyc), 64'(lat));
    chk({tag, "/busy_cycles"}, 64'(busy_cnt), 64'(lat > 0 ? lat - 1 : flush_cyc));
    chk({tag, "/busy_and_done"}, 64'(overlap), 64'd0);
    chk({tag, "/result_held"}, 64'(moved), 64'd0);
    chk({tag, "/result"}, 64'(result), 64'(exp));
    if (pulse_chk) begin
      @(negedge clk);
      chk({tag, "/done_pulse"}, 64'(done), 64'd0);
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp, input int lat);
    @(negedge clk);
    issue(o, a, b);
    track(tag, exp, lat, 0, 0, 1'b1);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; operand1 = '0; operand2 = '0;
    repeat (3) @(negedge clk);
    chk("reset/busy", 64'(busy), 64'd0);
    chk("reset/done", 64'(done), 64'd0);
    chk("reset/result", 64'(result), 64'd0);
    rst = 1'b0;

    do_op("mul",      3'd0, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB, LAT_MUL);
    do_op("mul_nn",   3'd0, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h9,        LAT_MUL);
    do_op("mulh",     3'd1, 32'h80000000, 32'h80000000, 32'h40000000, LAT_MUL);
    do_op("mulh_neg", 3'd1, 32'hFFFFFFFF, 32'h1,        32'hFFFFFFFF, LAT_MUL);
    do_op("mulhu",    3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT_MUL);
    do_op("mulhsu",   3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT_MUL);
    do_op("div",      3'd4, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, LAT_DIV);
    do_op("rem",      3'd6, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, LAT_DIV);
    do_op("divu",     3'd5, 32'd100,      32'd7,        32'd14,       LAT_DIV);
    do_op("divu_z",   3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, LAT_SPC);
    do_op("rem_z",    3'd6, 32'd5,        32'd0,        32'd5,        LAT_SPC);
    do_op("remu_z",   3'd7, 32'd9,        32'd0,        32'd9,        LAT_SPC);
    do_op("div_ovf",  3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT_SPC);
    do_op("rem_ovf",  3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0,        LAT_SPC);
    do_op("remu",     3'd7, 32'd100,      32'd7,        32'd2,        LAT_DIV);

    // Flush in cycle 10 of a DIVU: no done, result keeps the REMU value.
    @(negedge clk);
    issue(3'd5, 32'd100, 32'd7);
    track("flush", 32'd2, 0, 0, 10, 1'b0);

    // A second start during CALC must not disturb the running DIVU.
    @(negedge clk);
    issue(3'd5, 32'd100, 32'd7);
    track("ign_start", 32'd14, LAT_DIV, 5, 0, 1'b1);

    // Back-to-back: start the next op in the DONE cycle of the previous one.
    @(negedge clk);
    issue(3'd7, 32'd100, 32'd7);
    track("b2b_first", 32'd2, LAT_DIV, 0, 0, 1'b0);
    issue(3'd4, 32'hFFFFFFF9, 32'h2);
    track("b2b_second", 32'hFFFFFFFD, LAT_DIV, 0, 0, 1'b1);

    // Reset in cycle 5 of a MUL.
    @(negedge clk);
    issue(3'd0, 32'h7, 32'hFFFFFFFD);
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
      operand1 = $urandom;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid/busy", 64'(busy), 64'd0);
    chk("rst_mid/done", 64'(done), 64'd0);
    chk("rst_mid/result", 64'(result), 64'd0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (busy || done) seen = 1'b1;
    end
    chk("rst_mid/idle", 64'(seen), 64'd0);
    do_op("post_rst", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT_MUL);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised multi-cycle arithmetic unit for the RISC-V pipeline's EX stage, implementing the RV32M multiply/divide/remainder operations alongside the single-cycle ALU. Each operation is started with a one-cycle request and returns its result with a one-cycle completion pulse. While an operation is in progress the unit raises `busy`, which the hazard unit uses to stall the pipeline. Results follow RISC-V M-extension semantics, including divide-by-zero and signed-overflow cases.

## Interface
- `WIDTH`, 32, operand/result width in bits; legal range is ≥4.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `flush`  in  1  synchronous abort of the in-flight operation (pipeline flush).
- `op`  in  3  operation selector, mirroring funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `operand1`  in  WIDTH  rs1 value (dividend / multiplicand).
- `operand2`  in  WIDTH  rs2 value (divisor / multiplier).
- `busy`  out  1  high while in CALC.
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  out  WIDTH  registered result; held until the next completion or reset.

## Operation
- The state machine has three states: IDLE, CALC and DONE.
- **Start condition.** A start is accepted when `start`=1 and `flush`=0 while in IDLE or DONE. On acceptance the unit:
  - latches `op`;
  - latches the operand magnitudes and the sign flags (the signs used depend on `op`);
  - clears the iteration counter (`$clog2(WIDTH)` bits);
  - goes to CALC.
- **Requests outside IDLE/DONE.** `start` during CALC is ignored.
- **Multiplication (CALC).**
  - Iterative radix-2 shift-add on magnitudes, one bit per cycle, into a 2·WIDTH accumulator.
  - The product is negated at completion if the sign flags differ.
  - MUL returns bits [WIDTH-1:0]. MULH, MULHSU and MULHU return bits [2·WIDTH-1:WIDTH].
  - MULHSU treats `operand1` as signed and `operand2` as unsigned.
- **Division (CALC).**
  - Radix-2 restoring division on magnitudes, one quotient bit per cycle.
  - The quotient sign is s1 XOR s2. The remainder takes the sign of the dividend.
- **Leaving CALC.** At the edge where counter == WIDTH-1, the unit writes `result` and moves to DONE.
- **Special cases** bypass CALC; they are detected on acceptance and go straight to DONE with `result` written on that edge:
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return `operand1`.
  - Signed overflow (DIV/REM of -2^(WIDTH-1) by -1): DIV returns -2^(WIDTH-1); REM returns 0.
- **DONE.** `done`=1 for exactly one cycle, then the unit goes to IDLE. If a start is accepted in DONE, the unit goes to CALC (or back to DONE for a special case) instead.
- **Flush.** `flush`=1 in any state → IDLE at the next edge. No `done` is produced and `result` is unchanged. `flush` overrides `start` in the same cycle.
- **Reset.** `rst`=1 → IDLE, `busy`=0, `done`=0, `result`=0, counter=0. Reset takes priority over `flush` and `start`, including when it arrives mid-operation.

## Timing
- The reset value of every output is 0.
- Iterative operation: the cycle in which `start` is sampled is cycle 0. `busy` is high in cycles 1..WIDTH. `done` is high in cycle WIDTH+1 (cycle 33 for WIDTH=32).
- Special-case division: `done` is high in cycle 1 and `busy` never rises.
- `busy` and `done` are never high in the same cycle.
- `result` changes only on the edge that enters DONE, or on reset.
- Back-to-back operation: a start in a DONE cycle gives a gap of zero idle cycles.
- Operand inputs only need to be stable in the accepting cycle.

## Configuration
- `ALU_MULDIV_FAST_MUL_EN` defined:
  - All four multiply ops use a single combinational WIDTH×WIDTH signed/unsigned product, computed at acceptance.
  - Multiplies go directly to DONE, so `done` is in cycle 1 and `busy` never rises.
  - Division is unchanged.
- Undefined: multiplies use the iterative WIDTH-cycle path described above.

## Test plan
- MUL 7 × 0xFFFFFFFD (-3), WIDTH=32 → `result`=0xFFFFFFEB. `done` in cycle 33 (cycle 1 with the macro). `busy` high in cycles 1..32 (never with the macro).
- High-word products:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Signed and unsigned division:
  - DIV -7/2 → 0xFFFFFFFD.
  - REM -7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU 100/7 → 2.
  - Each completes in cycle 33.
- Special cases, each with `done` in cycle 1 and `busy` staying 0:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM 0x80000000/0xFFFFFFFF → 0.
- Flush and ignored start:
  - `flush` in cycle 10 of a DIVU → `busy`=0 from the next cycle, no `done`, `result` keeps the previous value.
  - `start` with different operands during CALC → ignored; the original result is returned.
- Reset and back-to-back:
  - `rst` in cycle 5 of a MUL → next cycle all outputs are 0 and the state is IDLE.
  - `start` asserted in a DONE cycle → the new operation's `done` arrives 33 cycles later, and the first result is observed correctly in that DONE cycle.
